sb_config_loader: RTL
=====================

// Module: sb_config_loader
// PURPOSE
//  Serial configuration loader feeding the config_data ports of a row of NUM_SB fullSB switchboxes.
//  Accepts a bit-serial stream under a valid/ready handshake into a shadow register, then validates it.
//  Commits to the live outputs atomically, so switchboxes never see partial configuration.
//  Rejects illegal switchbox words and keeps the previous live configuration when it does.
// PARAMETERS
//  NUM_SB  4  number of switchboxes driven; chain length = NUM_SB*SB_CFG_W bits
//  SB_CFG_W  9  bits per switchbox word (fixed by fullSB; taken from package, not overridable)
// PORTS
//  clk  in  1  system clock, all state on rising edge
//  nrst  in  1  asynchronous active-low reset
//  cfg_start  in  1  one-cycle pulse: begin (or restart) a load
//  cfg_valid  in  1  cfg_bit is valid this cycle
//  cfg_bit  in  1  serial config bit, MSB of flat vector first
//  cfg_ready  out  1  loader accepts a bit this cycle (high only in SHIFT)
//  config_data  out  NUM_SB*9  live config; SB k owns [9k+8:9k]
//  busy  out  1  high in SHIFT, CHECK and COMMIT
//  done  out  1  one-cycle pulse: load committed
//  err  out  1  sticky until next cfg_start: last load rejected
//  err_sb  out  $clog2(NUM_SB) (min 1)  lowest SB index that failed check
// BEHAVIOUR
//  Reset (async, nrst=0): state IDLE, config_data=0 (all ports off), shadow=0, counter=0; cfg_ready, busy, done, err, err_sb = 0.
//  SB word: [8]=mode, [7:6]=N, [5:4]=E, [3:2]=S, [1:0]=W; field 00 off, 01 receive, 10 drive, 11 reserved.
//  FSM IDLE -> SHIFT on cfg_start; the counter clears, err clears.
//  SHIFT: a bit is accepted when cfg_valid&cfg_ready; shadow <= {shadow[N-2:0],cfg_bit}; the counter increments.
//   The bit accepted when counter==NUM_SB*9-1 is the last; the next state is CHECK and cfg_ready drops the following cycle.
//   cfg_valid without cfg_ready (IDLE/CHECK/COMMIT) is ignored; no bit is lost or shifted.
//  CHECK (1 cycle): per SB, illegal if any field==11 or more than 2 fields==10.
//   Any illegal -> IDLE, err=1, err_sb=lowest illegal index, config_data unchanged.
//   All legal -> COMMIT.
//  COMMIT (1 cycle): config_data <= shadow; done=1 in the next cycle (first IDLE cycle), so config and done become visible together.
//  Latency: last bit accepted at cycle T -> CHECK at T+1 -> COMMIT at T+2 -> config_data/done visible at T+3.
//  cfg_start in SHIFT or CHECK: abort and restart SHIFT with counter=0; the partial shadow is discarded; config_data is untouched.
//  cfg_start in COMMIT: the commit completes, then the loader enters SHIFT directly; done still pulses.
//  cfg_start together with the final accepted bit: the restart wins; the bit is discarded.
//  Reset mid-load: config_data returns to 0 immediately (async); no partial commit ever reaches the outputs.
//  done and err are never high together.
// STRUCTURE
//  Package svfpga_cfg_pkg:
//   SB_CFG_W=9; field localparams (MODE_BIT, N_MSB, E_MSB, S_MSB, W_MSB);
//   typedef enum logic[1:0] {PORT_OFF, PORT_RX, PORT_DRV, PORT_RSVD} sb_port_e;
//   typedef enum {IDLE, SHIFT, CHECK, COMMIT} ldr_state_e.
//  Sub-module sb_cfg_check: combinational, 9-bit word in, legal out; instantiated NUM_SB times in a generate loop.
//  Top: FSM, bit counter, shadow shift register, live register, priority encoder for err_sb.
// TESTING (bench drives cfg_bit from a 9-bit word list, NUM_SB=4)
//  Reset -> config_data=0, cfg_ready=0, busy=0; cfg_valid pulses in IDLE leave the shadow unchanged.
//  Load SB3..SB0 = 0_10_01_01_00, 0_01_10_01_00, 1_10_10_00_00, 0_00_10_00_10 with valid held high -> config_data = those words; done 3 cycles after the 36th bit.
//  Same stream with random cfg_valid gaps -> identical result; cfg_ready stays high throughout SHIFT.
//  SB1 word 0_11_00_00_00, SB2 word 0_10_10_10_00 -> err=1, err_sb=1, config_data keeps the previous load, no done.
//  cfg_start after 20 bits, then a full legal stream -> only the second stream is committed; one done pulse.
//  Assert nrst mid-SHIFT after a prior commit -> config_data=0 that same cycle, state IDLE, no done or err.

Source files
------------

// File: rtl/svfpga_cfg_pkg.sv
// Shared definitions for the switchbox configuration path: word layout,
// port-field encoding and loader state encoding.
package svfpga_cfg_pkg;

  localparam int SB_CFG_W = 9;
  localparam int MODE_BIT = 8;
  localparam int N_MSB    = 7;
  localparam int E_MSB    = 5;
  localparam int S_MSB    = 3;
  localparam int W_MSB    = 1;

  typedef enum logic [1:0] {
    PORT_OFF  = 2'b00,
    PORT_RX   = 2'b01,
    PORT_DRV  = 2'b10,
    PORT_RSVD = 2'b11
  } sb_port_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/sb_cfg_check.sv
// Legality check for one switchbox word: no reserved port field and at most
// two ports configured as drivers.
module sb_cfg_check
  import svfpga_cfg_pkg::*;
(
  input  logic [SB_CFG_W-1:0] word,
  output logic                legal
);

  logic [3:0][1:0] fld;
  logic            rsvd;
  logic [2:0]      drv_cnt;

  assign fld = {word[N_MSB -: 2], word[E_MSB -: 2], word[S_MSB -: 2], word[W_MSB -: 2]};

  always_comb begin
    rsvd    = 1'b0;
    drv_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (sb_port_e'(fld[i]) == PORT_RSVD) rsvd = 1'b1;
      if (sb_port_e'(fld[i]) == PORT_DRV)  drv_cnt = drv_cnt + 3'd1;
    end
    legal = !rsvd && (drv_cnt <= 3'd2);
  end

endmodule

// File: rtl/sb_config_loader.sv
// Bit-serial configuration loader: shifts a stream into a shadow register,
// checks every switchbox word, then commits atomically to the live outputs.
module sb_config_loader
  import svfpga_cfg_pkg::*;
#(
  parameter  int NUM_SB = 4,
  localparam int CFG_W  = NUM_SB * SB_CFG_W,
  localparam int ERR_W  = (NUM_SB > 1) ? $clog2(NUM_SB) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] config_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_sb
);

  localparam int               CNT_W    = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_W - 1);

  ldr_state_e        state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CFG_W-1:0]  shadow_q;
  logic [NUM_SB-1:0] sb_legal;
  logic              all_legal;
  logic [ERR_W-1:0]  first_bad;
  logic              accept;
  logic              last_bit;

  for (genvar k = 0; k < NUM_SB; k++) begin : g_chk
    sb_cfg_check u_chk (
      .word  (shadow_q[k*SB_CFG_W +: SB_CFG_W]),
      .legal (sb_legal[k])
    );
  end

  assign all_legal = &sb_legal;

  // Scan from the top so the lowest failing index is the one left standing.
  always_comb begin
    first_bad = '0;
    for (int k = NUM_SB - 1; k >= 0; k--) begin
      if (!sb_legal[k]) first_bad = ERR_W'(k);
    end
  end

  assign accept   = cfg_valid && cfg_ready;
  assign last_bit = accept && (cnt_q == LAST_CNT);

  always_comb begin
    state_nxt = state_q;
    cfg_ready = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        if (!cfg_start && last_bit) state_nxt = CHECK;
      end
      CHECK: begin
        if (cfg_start)      state_nxt = SHIFT;
        else if (all_legal) state_nxt = COMMIT;
        else                state_nxt = IDLE;
      end
      COMMIT: begin
        state_nxt = cfg_start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A restart always wins over a bit arriving in the same cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else if (cfg_start) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else if (accept) begin
      cnt_q    <= cnt_q + 1'b1;
      shadow_q <= {shadow_q[CFG_W-2:0], cfg_bit};
    end
  end

  // Live config and done update on the same edge, so they appear together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      config_data <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state_q == COMMIT);
      if (state_q == COMMIT) config_data <= shadow_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err    <= 1'b0;
      err_sb <= '0;
    end else if (cfg_start) begin
      err    <= 1'b0;
      err_sb <= '0;
    end else if (state_q == CHECK && !all_legal) begin
      err    <= 1'b1;
      err_sb <= first_bad;
    end
  end

endmodule
